// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the 8-bit
//                datapath, with a bounded instruction-memory wait and a
//                retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             imem_ack,
    input  logic [1:0]       opcode,
    output logic             imem_req,
    output logic             ir_load,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic [1:0]       alu_op,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    localparam int WAIT_W = $clog2(TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [1:0] C_OP_JUMP = 2'b10;
    localparam logic [1:0] C_OP_HALT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_err;
    logic [CNT_W-1:0]   r_retired;

    // Boundary destination shared by WB and jump-EXEC.
    state_t             w_boundary;
    assign w_boundary = stop ? S_IDLE : S_FETCH;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_err     <= 1'b0;
            r_retired <= '0;
        end else begin
            // Held at zero outside FETCH so every entry starts a fresh wait.
            if (r_state != S_FETCH) begin
                r_wait <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_state <= S_DECODE;
                    end else if (r_wait == C_WAIT_LAST) begin
                        r_state <= S_HALT;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_DECODE: begin
                    r_state <= (opcode == C_OP_HALT) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    if (opcode == C_OP_JUMP) begin
                        r_retired <= r_retired + 1'b1;
                        r_state   <= w_boundary;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    r_retired <= r_retired + 1'b1;
                    r_state   <= w_boundary;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode from the state register, so they fall with reset.
    always_comb begin
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        reg_write = 1'b0;
        alu_op    = 2'b00;
        busy      = 1'b0;
        halted    = 1'b0;
        case (r_state)
            S_FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
                ir_load  = imem_ack;
            end
            S_DECODE: begin
                busy = 1'b1;
            end
            S_EXEC: begin
                busy   = 1'b1;
                alu_op = opcode;
                if (opcode == C_OP_JUMP) begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                end
            end
            S_WB: begin
                busy      = 1'b1;
                reg_write = 1'b1;
                pc_write  = 1'b1;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign err     = r_err;
    assign retired = r_retired;
    assign state   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Directed self-checking bench for multicycle_ctrl
//                (TIMEOUT=15, CNT_W=2 so counter wrap is reachable).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 2;

    logic             clock;
    logic             reset;
    logic             start;
    logic             stop;
    logic             imem_ack;
    logic [1:0]       opcode;
    logic             imem_req;
    logic             ir_load;
    logic             pc_write;
    logic             pc_src;
    logic             reg_write;
    logic [1:0]       alu_op;
    logic             busy;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .imem_ack  (imem_ack),
        .opcode    (opcode),
        .imem_req  (imem_req),
        .ir_load   (ir_load),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .alu_op    (alu_op),
        .busy      (busy),
        .halted    (halted),
        .err       (err),
        .retired   (retired),
        .state     (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Packs the strobes as {imem_req, ir_load, pc_write, pc_src, reg_write, alu_op}.
    function automatic logic [31:0] strobes();
        return {25'd0, imem_req, ir_load, pc_write, pc_src, reg_write, alu_op};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_state", state, 0);
        check("rst_strobes", strobes(), 0);
        check("rst_retired", retired, 0);
        check("rst_err", err, 0);
        tick();
        reset = 1'b0;
    endtask

    int req_cnt;

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; imem_ack = 1'b0; opcode = 2'b00;
        #2;
        do_reset();

        // Idle with start low
        for (int i = 0; i < 10; i++) tick();
        check("idle_state", state, 0);
        check("idle_strobes", strobes(), 0);
        check("idle_busy_halted", {busy, halted, err}, 0);
        check("idle_retired", retired, 0);

        // R-type, immediate ack
        start = 1'b1; imem_ack = 1'b1; opcode = 2'b00;
        tick(); start = 1'b0; #1;
        check("r_fetch_state", state, 1);
        check("r_fetch_strobes", strobes(), 7'b1100000);
        check("r_fetch_busy", busy, 1);
        tick();
        check("r_decode_state", state, 2);
        check("r_decode_strobes", strobes(), 0);
        tick();
        check("r_exec_state", state, 3);
        check("r_exec_strobes", strobes(), 0);
        tick();
        check("r_wb_state", state, 4);
        check("r_wb_strobes", strobes(), 7'b0010100);
        check("r_wb_retired", retired, 0);
        tick();
        check("r_next_fetch", state, 1);
        check("r_retired", retired, 1);

        // Jump follows back-to-back
        opcode = 2'b10;
        tick();
        check("j_decode_state", state, 2);
        tick();
        check("j_exec_state", state, 3);
        check("j_exec_strobes", strobes(), 7'b0011010);
        tick();
        check("j_next_fetch", state, 1);
        check("j_retired", retired, 2);

        // I-type with stop raised during EXEC
        opcode = 2'b01;
        tick(); tick();
        stop = 1'b1; #1;
        check("i_exec_alu", {state, alu_op}, {3'd3, 2'b01});
        tick();
        check("i_wb_state", state, 4);
        check("i_wb_regwrite", reg_write, 1);
        tick();
        stop = 1'b0; #1;
        check("stop_idle", state, 0);
        check("stop_retired", retired, 3);
        check("stop_busy", busy, 0);

        // Halt instruction
        start = 1'b1; opcode = 2'b11;
        tick(); start = 1'b0;
        tick();
        check("h_decode_state", state, 2);
        tick();
        check("h_state", state, 5);
        check("h_flags", {halted, busy, err}, 3'b100);
        check("h_retired", retired, 3);
        for (int i = 0; i < 3; i++) tick();
        check("h_sticky", state, 5);
        check("h_strobes", strobes(), 0);

        do_reset();
        check("post_halt_reset", {state, halted}, 0);

        // Fetch timeout, ack never arrives
        imem_ack = 1'b0; opcode = 2'b00; start = 1'b1;
        tick(); start = 1'b0;
        req_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req) req_cnt++;
            tick();
        end
        check("to_req_cycles", req_cnt, TIMEOUT);
        check("to_state", state, 5);
        check("to_flags", {err, halted}, 2'b11);
        check("to_strobes", strobes(), 0);

        do_reset();
        check("to_err_cleared", err, 0);

        // Ack in the final allowed fetch cycle
        start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("late_still_fetch", state, 1);
        imem_ack = 1'b1; #1;
        check("late_ir_load", ir_load, 1);
        tick();
        check("late_decode", state, 2);
        check("late_err", err, 0);

        // Async reset in the middle of WB
        tick(); tick();
        check("mid_wb_state", state, 4);
        check("mid_wb_regwrite", reg_write, 1);
        #2 reset = 1'b1;
        #1;
        check("async_regwrite", reg_write, 0);
        check("async_pcwrite", pc_write, 0);
        check("async_state", state, 0);
        check("async_retired", retired, 0);
        tick();
        reset = 1'b0;

        // Five jumps wrap a 2-bit counter to 1
        opcode = 2'b10; imem_ack = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            tick(); tick(); tick();
            if (n == 3) check("wrap_pre", retired, 3);
        end
        check("wrap_retired", retired, 1);
        check("wrap_state", state, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
